// File: rtl/core_pkg.sv
// Shared core-wide constants and the fetch-entry record handed from fetch to decode.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam int PC_INCR = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small shift-register FIFO. The head is always entry 0, so it keeps its last value
// when the FIFO drains; flush only clears the count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             pop_eff, push_eff;
  logic [CW-1:0]    wr_idx;

  assign pop_eff  = pop_i && (count_q != '0);
  assign push_eff = push_i && ((count_q != CW'(DEPTH)) || pop_eff);
  assign wr_idx   = pop_eff ? count_q - CW'(1) : count_q;

  // NOTE: every signal written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      // Shift only when something remains behind the head, so a drained head holds its value.
      if (pop_eff && count_q > CW'(1)) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      end
      if (push_eff) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) mem_d[i] = push_data_i;
        end
      end
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  // NOTE: storage is reset as well because the head is a visible output that must read 0 out of reset; at this depth it is only a few flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[0];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the fetch pointer, issues credit-limited word requests,
// pairs in-order responses with their pc and queues them for decode; redirects squash younger work.
module ifetch_queue #(
  parameter int              XLEN     = core_pkg::XLEN,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] fetch_pc
);
  import core_pkg::fetch_entry_t;
  import core_pkg::PC_INCR;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   out_count;
  logic [CW-1:0]   unused_pend_count;
  logic [XLEN-1:0] pend_pc;
  fetch_entry_t    out_head, out_push_data;
  logic [CW:0]     occupancy;
  logic            issue, drop_now, out_push, id_pop;

  // Every outstanding request owns an output slot, so a response can never find the queue full.
  assign occupancy      = {1'b0, out_count} + {1'b0, inflight_q};
  assign imem_req_valid = rst && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
  assign issue          = imem_req_valid && imem_req_ready;
  assign drop_now       = imem_rsp_valid && (drop_q != '0);
  assign out_push       = imem_rsp_valid && !drop_now && !redirect_valid;
  assign id_pop         = id_valid && id_ready;
  assign out_push_data  = '{pc: pend_pc, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rsp_valid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      // No issue can happen in a redirect cycle, so only this cycle's response leaves the stale set.
      drop_d     = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (issue)    fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
      if (drop_now) drop_d     = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (issue),
    .push_data_i (fetch_pc_q),
    .pop_i       (imem_rsp_valid),
    .flush_i     (1'b0),
    .count_o     (unused_pend_count),
    .head_o      (pend_pc)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (out_push),
    .push_data_i (out_push_data),
    .pop_i       (id_pop),
    .flush_i     (redirect_valid),
    .count_o     (out_count),
    .head_o      (out_head)
  );

  assign id_valid      = (out_count != '0);
  assign id_pc         = out_head.pc;
  assign id_instr      = out_head.instr;
  assign imem_req_addr = fetch_pc_q;
  assign fetch_pc      = fetch_pc_q;

  a_rsp_needs_inflight: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && inflight_q == '0));
  a_req_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
    imem_req_addr[1:0] == 2'b00);

endmodule
